maj_graph_sequencer: RTL and testbench



---
 rtl/maj_graph_sequencer_pkg.sv | 38 +++
 rtl/maj_graph_sequencer_if.sv | 33 +++
 rtl/maj_graph_sequencer_maj3.sv | 22 ++
 rtl/maj_graph_sequencer.sv | 144 ++++++++++++++
 tb/tb_maj_graph_sequencer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maj_graph_sequencer_pkg.sv
// Shared definitions for the majority-graph sequencer.
// Holds sizing constants, the operand select encoding, the node entry
// layout, the FSM state type and the node-count clamp helper.
package maj_seq_pkg;

  localparam int MAX_NODES = 16;
  localparam int SEL_W     = 5;
  localparam int NODE_W    = 3 * (SEL_W + 1);
  localparam int PTR_W     = $clog2(MAX_NODES);
  localparam int LEN_W     = PTR_W + 1;

  localparam logic [SEL_W-1:0] SEL_ZERO  = '0;
  localparam logic [SEL_W-1:0] SEL_X0    = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_NODE0 = SEL_W'(8);
  // first select value past the last node; everything from here up is illegal
  localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(8 + MAX_NODES);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_NODES);

  typedef struct packed {
    logic             inv_c;
    logic [SEL_W-1:0] sel_c;
    logic             inv_b;
    logic [SEL_W-1:0] sel_b;
    logic             inv_a;
    logic [SEL_W-1:0] sel_a;
  } node_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

endpackage

// File: rtl/maj_graph_sequencer_if.sv
// Bus bundle for the majority-graph sequencer.
// cfg_*  : program / node-count writes, accepted while cfg_ready
// in_*   : input vector handshake (in_x bit i = xi)
// out_*  : result handshake carrying out_bit and out_err
// master drives config, input vectors and out_ready; slave is the sequencer.
interface maj_graph_sequencer_if;
  import maj_seq_pkg::*;

  logic              cfg_we;
  logic [PTR_W-1:0]  cfg_addr;
  logic [NODE_W-1:0] cfg_data;
  logic              cfg_len_we;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_ready;
  logic              in_valid;
  logic [6:0]        in_x;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              out_bit;
  logic              out_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_len_we, cfg_len, in_valid, in_x, out_ready,
    input  cfg_ready, in_ready, out_valid, out_bit, out_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_len_we, cfg_len, in_valid, in_x, out_ready,
    output cfg_ready, in_ready, out_valid, out_bit, out_err
  );

endinterface

// File: rtl/maj_graph_sequencer_maj3.sv
// Shared 3-input majority unit with per-operand inversion.
// a/b/c     : raw operand values
// inv_a/b/c : invert the matching operand before voting
// y         : MAJ(a^inv_a, b^inv_b, c^inv_c)
module maj3_unit (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic inv_a,
  input  logic inv_b,
  input  logic inv_c,
  output logic y
);

  logic aa, bb, cc;

  assign aa = a ^ inv_a;
  assign bb = b ^ inv_b;
  assign cc = c ^ inv_c;
  assign y  = (aa & bb) | (aa & cc) | (bb & cc);

endmodule

// File: rtl/maj_graph_sequencer.sv
// Time-multiplexed majority-inverter graph evaluator over x0..x6.
// One node of the stored program is evaluated per cycle through a single
// maj3_unit; the last active node's value is returned on the out handshake.
// clk   : clock
// rst_n : asynchronous active-low reset
// bus   : config, input-vector and result signals (slave side)
//
// state | meaning
// IDLE  | accept config writes and the next input vector
// EVAL  | evaluate node ptr, one node per cycle
// DONE  | hold result until out_ready
module maj_graph_sequencer
  import maj_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  maj_graph_sequencer_if.slave bus
);

  state_t               state, state_nxt;
  node_entry_t          prog [MAX_NODES];
  node_entry_t          cur;
  logic [LEN_W-1:0]     len, len_eff;
  logic [PTR_W-1:0]     ptr;
  logic [6:0]           x_reg;
  logic [MAX_NODES-1:0] node_val;
  logic                 err, out_bit_q, out_err_q;
  logic [1:0]           op_a, op_b, op_c;
  logic                 fault, maj_out, last, accept;

  // Returns {fault, value}. A node select is only legal if it points strictly
  // backwards; anything else reads 0 so stale node registers never leak out.
  function automatic logic [1:0] fetch(input logic [SEL_W-1:0]     sel,
                                       input logic [6:0]           x,
                                       input logic [MAX_NODES-1:0] nv,
                                       input logic [PTR_W-1:0]     p);
    logic [SEL_W-1:0] k;
    k = sel - SEL_NODE0;
    if (sel == SEL_ZERO)
      fetch = 2'b00;
    else if (sel < SEL_NODE0)
      fetch = {1'b0, x[3'(sel - SEL_X0)]};
    else if ((sel >= SEL_LIMIT) || (k >= SEL_W'(p)))
      fetch = 2'b10;
    else
      fetch = {1'b0, nv[PTR_W'(k)]};
  endfunction

  assign cur   = prog[ptr];
  assign op_a  = fetch(cur.sel_a, x_reg, node_val, ptr);
  assign op_b  = fetch(cur.sel_b, x_reg, node_val, ptr);
  assign op_c  = fetch(cur.sel_c, x_reg, node_val, ptr);
  assign fault = op_a[1] | op_b[1] | op_c[1];

  maj3_unit u_maj3 (
    .a     (op_a[0]),
    .b     (op_b[0]),
    .c     (op_c[0]),
    .inv_a (cur.inv_a),
    .inv_b (cur.inv_b),
    .inv_c (cur.inv_c),
    .y     (maj_out)
  );

  assign last   = ({1'b0, ptr} == (len - 1'b1));
  assign accept = (state == IDLE) && bus.in_valid;
  // a node-count write in the accept cycle governs that same evaluation
  assign len_eff = bus.cfg_len_we ? clamp_len(bus.cfg_len) : len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.cfg_ready = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready  = 1'b1;
        bus.cfg_ready = 1'b1;
        if (accept) state_nxt = (len_eff == '0) ? DONE : EVAL;
      end
      EVAL: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // program memory sits outside the reset domain
  always_ff @(posedge clk) begin
    if ((state == IDLE) && bus.cfg_we)
      prog[bus.cfg_addr] <= node_entry_t'(bus.cfg_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len       <= '0;
      ptr       <= '0;
      x_reg     <= '0;
      node_val  <= '0;
      err       <= 1'b0;
      out_bit_q <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_len_we) len <= clamp_len(bus.cfg_len);
          if (accept) begin
            x_reg <= bus.in_x;
            ptr   <= '0;
            err   <= 1'b0;
            if (len_eff == '0) begin
              out_bit_q <= 1'b0;
              out_err_q <= 1'b1;
            end
          end
        end
        EVAL: begin
          node_val[ptr] <= maj_out;
          err           <= err | fault;
          if (last) begin
            out_bit_q <= maj_out;
            out_err_q <= err | fault;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_bit = out_bit_q;
  assign bus.out_err = out_err_q;

endmodule

// File: tb/tb_maj_graph_sequencer.sv
module tb_maj_graph_sequencer;
  import maj_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  maj_graph_sequencer_if bus ();

  maj_graph_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference copy of what the program should be
  node_entry_t m_prog [16];
  int          m_len = 0;

  // Reference evaluation straight from the graph definition: walk nodes in
  // order, count ones among the three (possibly inverted) operands.
  function automatic logic [1:0] model_eval(input logic [6:0] x);
    logic       v [16];
    logic       e;
    logic [4:0] s [3];
    logic       iv [3];
    logic       opv;
    int         ones;
    int         k;
    e = 1'b0;
    if (m_len == 0) return 2'b10;
    for (int i = 0; i < m_len; i++) begin
      s[0] = m_prog[i].sel_a; iv[0] = m_prog[i].inv_a;
      s[1] = m_prog[i].sel_b; iv[1] = m_prog[i].inv_b;
      s[2] = m_prog[i].sel_c; iv[2] = m_prog[i].inv_c;
      ones = 0;
      for (int j = 0; j < 3; j++) begin
        k = int'(s[j]);
        if (k == 0) opv = 1'b0;
        else if (k < 8) opv = x[k-1];
        else if (k - 8 < i) opv = v[k-8];
        else begin
          opv = 1'b0;
          e = 1'b1;
        end
        if (opv ^ iv[j]) ones++;
      end
      v[i] = (ones >= 2);
    end
    return {e, v[m_len-1]};
  endfunction

  function automatic node_entry_t mk(input int sa, input int ia, input int sb,
                                     input int ib, input int sc, input int ic);
    node_entry_t e;
    e.sel_a = 5'(sa); e.inv_a = 1'(ia);
    e.sel_b = 5'(sb); e.inv_b = 1'(ib);
    e.sel_c = 5'(sc); e.inv_c = 1'(ic);
    return e;
  endfunction

  function automatic node_entry_t rand_entry(input int i);
    node_entry_t e;
    logic [4:0]  s [3];
    int          r;
    for (int j = 0; j < 3; j++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) s[j] = 5'($urandom_range(0, 31));
      else if (r < 5 || i == 0) s[j] = 5'($urandom_range(0, 7));
      else s[j] = 5'(8 + int'($urandom_range(0, i - 1)));
    end
    e.sel_a = s[0]; e.inv_a = 1'($urandom_range(0, 1));
    e.sel_b = s[1]; e.inv_b = 1'($urandom_range(0, 1));
    e.sel_c = s[2]; e.inv_c = 1'($urandom_range(0, 1));
    return e;
  endfunction

  task automatic write_node(input int addr, input node_entry_t e);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'(addr);
    bus.cfg_data = e;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
    m_prog[addr] = e;
  endtask

  task automatic write_len(input int l);
    @(negedge clk);
    bus.cfg_len_we = 1'b1;
    bus.cfg_len    = 5'(l);
    @(negedge clk);
    bus.cfg_len_we = 1'b0;
    m_len = (l > 16) ? 16 : l;
  endtask

  task automatic load_prog5();
    write_node(0, mk(5, 0, 6, 0, 7, 0));   // MAJ(x4,x5,x6)
    write_node(1, mk(1, 0, 3, 0, 4, 0));   // MAJ(x0,x2,x3)
    write_node(2, mk(4, 0, 5, 0, 9, 0));   // MAJ(x3,x4,n1)
    write_node(3, mk(3, 0, 8, 0, 10, 0));  // MAJ(x2,n0,n2)
    write_node(4, mk(1, 0, 2, 0, 11, 0));  // MAJ(x0,x1,n3)
    write_len(5);
  endtask

  // returns just after the accept edge
  task automatic start_vector(input logic [6:0] x, output bit to);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    to = !bus.in_ready;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // lat = clock edges after the accept edge until out_valid is seen
  task automatic wait_result(output int lat, output bit to);
    lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    to = !bus.out_valid;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vector(input logic [6:0] x, output logic b, output logic e,
                            output int lat, output bit to);
    bit t1, t2;
    start_vector(x, t1);
    wait_result(lat, t2);
    to = t1 | t2;
    b  = bus.out_bit;
    e  = bus.out_err;
    take_result();
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++;
    if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", bus.cfg_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if ({bus.out_bit, bus.out_err} !== 2'b00) begin errors++; $display("FAIL reset_out got bit=%b err=%b want 0 0", bus.out_bit, bus.out_err); end
  endtask

  task automatic test_prog5();
    logic [6:0] xs [4] = '{7'h7F, 7'h00, 7'h03, 7'h70};
    logic       want [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       b, e;
    logic [1:0] m;
    logic [6:0] x;
    int         lat;
    bit         to;
    load_prog5();
    for (int i = 0; i < 4; i++) begin
      run_vector(xs[i], b, e, lat, to);
      checks++;
      if (to || b !== want[i] || e !== 1'b0 || lat != 5) begin
        errors++;
        $display("FAIL prog5_x%h got bit=%b err=%b lat=%0d to=%0d want bit=%b err=0 lat=5", xs[i], b, e, lat, to, want[i]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      x = 7'($urandom);
      m = model_eval(x);
      run_vector(x, b, e, lat, to);
      checks++;
      if (to || {e, b} !== m || lat != 5) begin
        errors++;
        $display("FAIL prog5_rand x=%h got bit=%b err=%b lat=%0d want bit=%b err=%b lat=5", x, b, e, lat, m[0], m[1]);
      end
    end
  endtask

  task automatic test_inversion();
    logic b, e;
    int   lat;
    bit   to;
    write_node(0, mk(0, 1, 0, 1, 1, 0));
    write_len(1);
    run_vector(7'h00, b, e, lat, to);
    checks++;
    if (to || b !== 1'b1 || e !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL inv_const got bit=%b err=%b lat=%0d want bit=1 err=0 lat=1", b, e, lat);
    end
    write_node(0, mk(0, 0, 0, 0, 1, 1));
    run_vector(7'h01, b, e, lat, to);
    checks++;
    if (to || b !== 1'b0 || e !== 1'b0) begin
      errors++;
      $display("FAIL inv_x0 got bit=%b err=%b want bit=0 err=0", b, e);
    end
  endtask

  task automatic test_fault();
    logic b, e;
    int   lat;
    bit   to;
    // leave node register 1 holding a 1 so a stale read would show
    write_node(0, mk(0, 1, 0, 1, 0, 1));
    write_node(1, mk(0, 1, 0, 1, 0, 1));
    write_len(2);
    run_vector(7'h00, b, e, lat, to);
    checks++;
    if (to || b !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL fault_setup got bit=%b err=%b want bit=1 err=0", b, e);
    end
    write_node(0, mk(1, 0, 9, 0, 0, 0));   // MAJ(x0, n1 (forward), 0)
    write_node(1, mk(8, 0, 8, 0, 0, 0));   // MAJ(n0, n0, 0)
    run_vector(7'h01, b, e, lat, to);
    checks++;
    if (to || b !== 1'b0 || e !== 1'b1 || lat != 2) begin
      errors++;
      $display("FAIL fault_fwd got bit=%b err=%b lat=%0d want bit=0 err=1 lat=2", b, e, lat);
    end
    write_node(0, mk(31, 1, 1, 0, 0, 0));  // illegal select, inverted -> reads 1
    write_len(1);
    run_vector(7'h01, b, e, lat, to);
    checks++;
    if (to || b !== 1'b1 || e !== 1'b1) begin
      errors++;
      $display("FAIL fault_illegal got bit=%b err=%b want bit=1 err=1", b, e);
    end
    write_len(0);
    run_vector(7'h7F, b, e, lat, to);
    checks++;
    if (to || b !== 1'b0 || e !== 1'b1 || lat != 0) begin
      errors++;
      $display("FAIL fault_len0 got bit=%b err=%b lat=%0d want bit=0 err=1 lat=0", b, e, lat);
    end
  endtask

  task automatic test_random_programs();
    logic       b, e;
    logic [1:0] m;
    logic [6:0] x;
    int         l, lat;
    bit         to;
    for (int t = 0; t < 6; t++) begin
      l = (t == 5) ? 16 : int'($urandom_range(1, 16));
      for (int i = 0; i < l; i++) write_node(i, rand_entry(i));
      write_len((t == 5) ? 29 : l);   // last trial exercises the clamp
      for (int v = 0; v < 4; v++) begin
        x = 7'($urandom);
        m = model_eval(x);
        run_vector(x, b, e, lat, to);
        checks++;
        if (to || {e, b} !== m || lat != m_len) begin
          errors++;
          $display("FAIL rand_prog t=%0d x=%h got bit=%b err=%b lat=%0d want bit=%b err=%b lat=%0d",
                   t, x, b, e, lat, m[0], m[1], m_len);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic b, e;
    int   lat;
    bit   t1, t2;
    load_prog5();
    start_vector(7'h7F, t1);
    wait_result(lat, t2);
    checks++;
    if (t1 || t2 || bus.out_bit !== 1'b1) begin
      errors++;
      $display("FAIL bp_first got bit=%b to=%0d want bit=1", bus.out_bit, t1 | t2);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c=%0d got valid=%b bit=%b in_ready=%b want 1 1 0", c, bus.out_valid, bus.out_bit, bus.in_ready);
      end
      bus.in_valid = (c == 3);
      bus.in_x     = 7'h00;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    take_result();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_accept got valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    run_vector(7'h03, b, e, lat, t1);
    checks++;
    if (t1 || b !== 1'b1 || e !== 1'b0 || lat != 5) begin
      errors++;
      $display("FAIL bp_next got bit=%b err=%b lat=%0d want bit=1 err=0 lat=5", b, e, lat);
    end
  endtask

  task automatic test_cfg_lockout();
    logic b, e;
    int   lat, lat2;
    bit   t1, t2;
    load_prog5();
    start_vector(7'h01, t1);
    @(negedge clk);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 4'd3;
    bus.cfg_data   = mk(0, 1, 0, 1, 0, 1);  // would force n3 to 1
    bus.cfg_len_we = 1'b1;
    bus.cfg_len    = 5'd1;
    checks++;
    if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL lock_cfg_ready got %b want 0", bus.cfg_ready); end
    @(negedge clk);
    bus.cfg_we     = 1'b0;
    bus.cfg_len_we = 1'b0;
    wait_result(lat2, t2);
    lat = lat2 + 2;
    checks++;
    if (t1 || t2 || bus.out_bit !== 1'b0 || bus.out_err !== 1'b0 || lat != 5) begin
      errors++;
      $display("FAIL lock_cur got bit=%b err=%b lat=%0d want bit=0 err=0 lat=5", bus.out_bit, bus.out_err, lat);
    end
    take_result();
    run_vector(7'h01, b, e, lat, t1);
    checks++;
    if (t1 || b !== 1'b0 || e !== 1'b0 || lat != 5) begin
      errors++;
      $display("FAIL lock_next got bit=%b err=%b lat=%0d want bit=0 err=0 lat=5", b, e, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic       b, e;
    logic [1:0] m;
    int         lat;
    bit         to;
    load_prog5();
    start_vector(7'h7F, to);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_bit !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_during got valid=%b in_ready=%b bit=%b want 0 1 0", bus.out_valid, bus.in_ready, bus.out_bit);
    end
    m_len = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_after got valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    run_vector(7'h7F, b, e, lat, to);
    checks++;
    if (to || b !== 1'b0 || e !== 1'b1 || lat != 0) begin
      errors++;
      $display("FAIL rst_len_cleared got bit=%b err=%b lat=%0d want bit=0 err=1 lat=0", b, e, lat);
    end
    write_len(5);
    m = model_eval(7'h70);
    run_vector(7'h70, b, e, lat, to);
    checks++;
    if (to || {e, b} !== m || lat != 5) begin
      errors++;
      $display("FAIL rst_reload got bit=%b err=%b lat=%0d want bit=%b err=%b lat=5", b, e, lat, m[0], m[1]);
    end
  endtask

  initial begin
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.cfg_len_we = 1'b0;
    bus.cfg_len    = '0;
    bus.in_valid   = 1'b0;
    bus.in_x       = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_prog5();
    test_inversion();
    test_fault();
    test_random_programs();
    test_backpressure();
    test_cfg_lockout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
